alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl_if.sv | 43 ++++
 rtl/alu_issue_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Purpose : bundles the command, ALU and result handshake signals of alu_issue_ctrl.
// Latency : n/a (wires only).
// Backpr. : in_valid/in_ready on the command side, res_valid/res_ready on the result side.
// Ports   : in_*  upstream commands      alu_* operands/opcode/enable to the ALU, alu_dout back
//           res_* captured result        fifo_count command FIFO occupancy
// Modports: slave = the controller, master = whoever feeds commands, models the ALU and takes results.
interface alu_issue_ctrl_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_cmd;
  logic [7:0]    in_a;
  logic [7:0]    in_b;

  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [3:0]    alu_cmd;
  logic          alu_oe;
  logic [15:0]   alu_dout;

  logic          res_valid;
  logic          res_ready;
  logic [15:0]   res_data;
  logic [3:0]    res_cmd;
  logic          res_err;

  logic [CW-1:0] fifo_count;

  modport slave (
    input  in_valid, in_cmd, in_a, in_b, alu_dout, res_ready,
    output in_ready, alu_a, alu_b, alu_cmd, alu_oe,
           res_valid, res_data, res_cmd, res_err, fifo_count
  );

  modport master (
    output in_valid, in_cmd, in_a, in_b, alu_dout, res_ready,
    input  in_ready, alu_a, alu_b, alu_cmd, alu_oe,
           res_valid, res_data, res_cmd, res_err, fifo_count
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Purpose : queues ALU commands in a DEPTH-entry FIFO, issues them one at a time to an external
//           combinational ALU and holds each result until downstream takes it.
// Latency : push into empty FIFO at edge E0 -> res_valid after E0+2; one result per 2 cycles sustained.
// Backpr. : in_ready drops when the FIFO is full; a held result stays stable until res_ready=1.
// Ports   : clk, rst_n (async active-low) plus the slave side of alu_issue_ctrl_if.
module alu_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_issue_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] OP_DIV = 4'b0101;

  typedef struct packed {
    logic [3:0] cmd;
    logic [7:0] a;
    logic [7:0] b;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  logic            push;
  logic            pop;
  entry_t          in_entry;
  entry_t          head;
  logic            head_divz;

  // FSM and registered outputs
  state_t          state_q;
  logic [7:0]      alu_a_q;
  logic [7:0]      alu_b_q;
  logic [3:0]      alu_cmd_q;
  logic            alu_oe_q;
  logic            res_valid_q;
  logic [15:0]     res_data_q;
  logic [3:0]      res_cmd_q;
  logic            res_err_q;
  logic            cur_divz;

  assign in_entry    = {bus.in_cmd, bus.in_a, bus.in_b};
  assign bus.in_ready = (count_q < CW'(DEPTH));
  assign push        = bus.in_valid && bus.in_ready;

  // A pop hands the head entry to the operand registers: from IDLE whenever
  // something is queued, or from HOLD on the same edge the result is taken.
  assign pop = (count_q != '0) &&
               ((state_q == S_IDLE) || ((state_q == S_HOLD) && bus.res_ready));

  assign head      = mem_q[rd_ptr_q];
  assign head_divz = (head.cmd == OP_DIV) && (head.b == 8'd0);
  assign cur_divz  = (alu_cmd_q == OP_DIV) && (alu_b_q == 8'd0);

  // Pointers are AW bits wide, so DEPTH being a power of two makes them wrap for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty count makes every stale entry unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cmd_q   <= '0;
      alu_oe_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_cmd_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            alu_a_q   <= head.a;
            alu_b_q   <= head.b;
            alu_cmd_q <= head.cmd;
            // A divide by zero never enables the ALU; its result is synthesised below.
            alu_oe_q  <= !head_divz;
            state_q   <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          alu_oe_q    <= 1'b0;
          res_valid_q <= 1'b1;
          res_cmd_q   <= alu_cmd_q;
          if (cur_divz) begin
            // alu_dout is floating here, so it must not be sampled.
            res_data_q <= 16'hFFFF;
            res_err_q  <= 1'b1;
          end else begin
            res_data_q <= bus.alu_dout;
            res_err_q  <= 1'b0;
          end
          state_q <= S_HOLD;
        end

        S_HOLD: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            if (pop) begin
              alu_a_q   <= head.a;
              alu_b_q   <= head.b;
              alu_cmd_q <= head.cmd;
              alu_oe_q  <= !head_divz;
              state_q   <= S_ISSUE;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end

        default: begin
          state_q     <= S_IDLE;
          alu_oe_q    <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_cmd    = alu_cmd_q;
  assign bus.alu_oe     = alu_oe_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_cmd    = res_cmd_q;
  assign bus.res_err    = res_err_q;
  assign bus.fifo_count = count_q;

endmodule
